// File: rtl/vehicle_detector.sv
// Road-B loop conditioner: synchronise, debounce, latch a vehicle request until served,
// count arrivals and force the request high while the sensor looks stuck.
module vehicle_detector #(
   parameter int DEBOUNCE     = 4,
   parameter int STUCK_CYCLES = 1000,
   parameter int CNT_W        = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             loop_raw,
   input  logic             served,
   input  logic             count_clr,
   output logic             detectorB,
   output logic             arrival,
   output logic [CNT_W-1:0] car_count,
   output logic             fault
);

   localparam int DEB_W = $clog2(DEBOUNCE + 1);
   localparam int STK_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
   localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      QUAL_ON  = 3'd1,
      PRESENT  = 3'd2,
      QUAL_OFF = 3'd3,
      STUCK    = 3'd4
   } state_t;

   logic             s1, s2;
   state_t           state, state_next;
   logic [DEB_W-1:0] deb_cnt, deb_next;
   logic [STK_W-1:0] stuck_cnt, stuck_next;
   logic             arrival_next;
   logic             req, req_next;
   logic             fault_next;
   logic             detector_next;
   logic [CNT_W-1:0] count_next;

   // All outputs are registered from their next values so they change on the same edge as the state.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= IDLE;
         deb_cnt   <= '0;
         stuck_cnt <= '0;
         req       <= 1'b0;
         arrival   <= 1'b0;
         fault     <= 1'b0;
         detectorB <= 1'b0;
         car_count <= '0;
      end else begin
         s1        <= loop_raw;
         s2        <= s1;
         state     <= state_next;
         deb_cnt   <= deb_next;
         stuck_cnt <= stuck_next;
         req       <= req_next;
         arrival   <= arrival_next;
         fault     <= fault_next;
         detectorB <= detector_next;
         car_count <= count_next;
      end
   end

   always_comb begin
      state_next   = state;
      deb_next     = deb_cnt;
      stuck_next   = stuck_cnt;
      arrival_next = 1'b0;
      case (state)
         IDLE: begin
            if (s2) begin
               state_next = QUAL_ON;
               deb_next   = DEB_W'(1);
            end
         end
         QUAL_ON: begin
            if (!s2) begin
               state_next = IDLE;
               deb_next   = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_next   = PRESENT;
               arrival_next = 1'b1;
               stuck_next   = '0;
            end else begin
               deb_next = deb_cnt + DEB_W'(1);
            end
         end
         PRESENT: begin
            if (!s2) begin
               state_next = QUAL_OFF;
               deb_next   = DEB_W'(1);
            end else if (stuck_cnt == STK_LAST) begin
               state_next = STUCK;
               deb_next   = '0;
            end else begin
               stuck_next = stuck_cnt + STK_W'(1);
            end
         end
         QUAL_OFF: begin
            // A short dropout returns to PRESENT without resetting the stuck timer.
            if (s2) begin
               state_next = PRESENT;
            end else if (deb_cnt == DEB_LAST) begin
               state_next = IDLE;
               deb_next   = '0;
               stuck_next = '0;
            end else begin
               deb_next = deb_cnt + DEB_W'(1);
            end
         end
         STUCK: begin
            if (s2) begin
               deb_next = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_next = IDLE;
               deb_next   = '0;
               stuck_next = '0;
            end else begin
               deb_next = deb_cnt + DEB_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            deb_next   = '0;
            stuck_next = '0;
         end
      endcase
   end

   // A new arrival wins over a simultaneous served; the fault forces the request high.
   always_comb begin
      fault_next = (state_next == STUCK);
      if (arrival_next) begin
         req_next = 1'b1;
      end else if (served) begin
         req_next = 1'b0;
      end else begin
         req_next = req;
      end
      detector_next = req_next | fault_next;
      if (count_clr) begin
         count_next = arrival_next ? CNT_W'(1) : '0;
      end else if (arrival_next && (car_count != CNT_MAX)) begin
         count_next = car_count + CNT_W'(1);
      end else begin
         count_next = car_count;
      end
   end

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed bench for vehicle_detector with DEBOUNCE=4, STUCK_CYCLES=1000, CNT_W=2.
module tb_vehicle_detector;

   logic       clock;
   logic       rst;
   logic       loop_raw;
   logic       served;
   logic       count_clr;
   logic       detectorB;
   logic       arrival;
   logic [1:0] car_count;
   logic       fault;

   int checks = 0;
   int errors = 0;

   vehicle_detector #(
      .DEBOUNCE     (4),
      .STUCK_CYCLES (1000),
      .CNT_W        (2)
   ) dut (
      .clock     (clock),
      .rst       (rst),
      .loop_raw  (loop_raw),
      .served    (served),
      .count_clr (count_clr),
      .detectorB (detectorB),
      .arrival   (arrival),
      .car_count (car_count),
      .fault     (fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; loop_raw = 1'b1; served = 1'b0; count_clr = 1'b0;
      tick(3);
      checks++; if (detectorB !== 1'b0) begin errors++; $display("[TB] FAIL reset_detectorB got %0b expected 0", detectorB); end
      checks++; if (arrival !== 1'b0) begin errors++; $display("[TB] FAIL reset_arrival got %0b expected 0", arrival); end
      checks++; if (car_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_car_count got %0d expected 0", car_count); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault got %0b expected 0", fault); end
      loop_raw = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(8);
   endtask

   task automatic test_latency;
      loop_raw = 1'b1;
      tick(5);
      checks++; if ({arrival, detectorB} !== 2'b00) begin errors++; $display("[TB] FAIL latency_early got %b expected 00", {arrival, detectorB}); end
      tick(1);
      checks++; if ({arrival, detectorB} !== 2'b11) begin errors++; $display("[TB] FAIL latency_edge6 got %b expected 11", {arrival, detectorB}); end
      checks++; if (car_count !== 2'd1) begin errors++; $display("[TB] FAIL latency_count got %0d expected 1", car_count); end
      tick(1);
      checks++; if ({arrival, detectorB} !== 2'b01) begin errors++; $display("[TB] FAIL latency_pulse_width got %b expected 01", {arrival, detectorB}); end
      loop_raw = 1'b0;
      tick(8);
      checks++; if (detectorB !== 1'b1) begin errors++; $display("[TB] FAIL req_held_after_departure got %0b expected 1", detectorB); end
   endtask

   task automatic test_served;
      served = 1'b1;
      tick(1);
      served = 1'b0;
      checks++; if (detectorB !== 1'b0) begin errors++; $display("[TB] FAIL served_clear got %0b expected 0", detectorB); end
      loop_raw = 1'b1;
      tick(5);
      served = 1'b1;
      tick(1);
      served = 1'b0;
      checks++; if ({arrival, detectorB} !== 2'b11) begin errors++; $display("[TB] FAIL served_vs_arrival got %b expected 11", {arrival, detectorB}); end
      checks++; if (car_count !== 2'd2) begin errors++; $display("[TB] FAIL served_count got %0d expected 2", car_count); end
      loop_raw = 1'b0;
      tick(8);
      served = 1'b1;
      tick(1);
      served = 1'b0;
      checks++; if (detectorB !== 1'b0) begin errors++; $display("[TB] FAIL served_clear2 got %0b expected 0", detectorB); end
   endtask

   task automatic test_short_runs;
      int pulses;
      pulses = 0;
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      checks++; if (car_count !== 2'd0) begin errors++; $display("[TB] FAIL count_clr got %0d expected 0", car_count); end
      for (int r = 0; r < 5; r++) begin
         loop_raw = 1'b1;
         for (int c = 0; c < 3; c++) begin tick(1); if (arrival) pulses++; end
         loop_raw = 1'b0;
         for (int c = 0; c < 3; c++) begin tick(1); if (arrival) pulses++; end
      end
      tick(4);
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL short_run_pulses got %0d expected 0", pulses); end
      checks++; if ({detectorB, car_count} !== 3'b000) begin errors++; $display("[TB] FAIL short_run_outputs got %b expected 000", {detectorB, car_count}); end
   endtask

   task automatic test_saturation;
      logic [1:0] expected;
      for (int i = 1; i <= 5; i++) begin
         expected = (i > 3) ? 2'd3 : 2'(i);
         loop_raw = 1'b1;
         tick(6);
         checks++; if ({arrival, car_count} !== {1'b1, expected}) begin errors++; $display("[TB] FAIL sat_arrival_%0d got %b expected %b", i, {arrival, car_count}, {1'b1, expected}); end
         loop_raw = 1'b0;
         tick(8);
      end
      loop_raw = 1'b1;
      tick(5);
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      checks++; if ({arrival, car_count} !== 3'b101) begin errors++; $display("[TB] FAIL clr_with_arrival got %b expected 101", {arrival, car_count}); end
      loop_raw = 1'b0;
      tick(8);
      served = 1'b1;
      tick(1);
      served = 1'b0;
      checks++; if ({detectorB, car_count} !== 3'b001) begin errors++; $display("[TB] FAIL sat_final got %b expected 001", {detectorB, car_count}); end
   endtask

   task automatic test_stuck;
      loop_raw = 1'b1;
      tick(1005);
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL stuck_early got %0b expected 0", fault); end
      tick(1);
      checks++; if ({fault, detectorB} !== 2'b11) begin errors++; $display("[TB] FAIL stuck_set got %b expected 11", {fault, detectorB}); end
      served = 1'b1;
      tick(3);
      checks++; if ({fault, detectorB} !== 2'b11) begin errors++; $display("[TB] FAIL stuck_ignores_served got %b expected 11", {fault, detectorB}); end
      served = 1'b0;
      checks++; if (car_count !== 2'd2) begin errors++; $display("[TB] FAIL stuck_count got %0d expected 2", car_count); end
      loop_raw = 1'b0;
      tick(5);
      checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL stuck_exit_early got %0b expected 1", fault); end
      tick(1);
      checks++; if ({fault, detectorB, arrival} !== 3'b000) begin errors++; $display("[TB] FAIL stuck_exit got %b expected 000", {fault, detectorB, arrival}); end
   endtask

   task automatic test_bounce;
      int pulses;
      pulses = 0;
      loop_raw = 1'b1;
      tick(6);
      checks++; if (arrival !== 1'b1) begin errors++; $display("[TB] FAIL bounce_arrival got %0b expected 1", arrival); end
      loop_raw = 1'b0;
      tick(2);
      loop_raw = 1'b1;
      for (int c = 0; c < 12; c++) begin tick(1); if (arrival) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL bounce_pulses got %0d expected 0", pulses); end
      loop_raw = 1'b0;
      tick(8);
      checks++; if ({detectorB, car_count} !== 3'b111) begin errors++; $display("[TB] FAIL bounce_outputs got %b expected 111", {detectorB, car_count}); end
   endtask

   task automatic test_async_reset;
      loop_raw = 1'b1;
      tick(4);
      #2 rst = 1'b0;
      #1;
      checks++; if ({detectorB, arrival, fault, car_count} !== 5'b00000) begin errors++; $display("[TB] FAIL async_reset_qual got %b expected 00000", {detectorB, arrival, fault, car_count}); end
      rst = 1'b1;
      tick(5);
      checks++; if (arrival !== 1'b0) begin errors++; $display("[TB] FAIL requal_early got %0b expected 0", arrival); end
      tick(1);
      checks++; if ({arrival, car_count} !== 3'b101) begin errors++; $display("[TB] FAIL requal got %b expected 101", {arrival, car_count}); end
      tick(1000);
      checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL restuck got %0b expected 1", fault); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({detectorB, arrival, fault, car_count} !== 5'b00000) begin errors++; $display("[TB] FAIL async_reset_stuck got %b expected 00000", {detectorB, arrival, fault, car_count}); end
      loop_raw = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(10);
      checks++; if ({detectorB, fault} !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_idle got %b expected 00", {detectorB, fault}); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_served();
      test_short_runs();
      test_saturation();
      test_stuck();
      test_bounce();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
